// File: rtl/uart_pkg.sv
// Shared UART definitions: Gray-coded FSM states (common with the transmitter),
// parity type constants and the mid-bit sample points derived from the prescale.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b010;
  localparam logic [2:0] ST_STOP   = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Three samples straddle the bit centre; the vote resolves on the last one.
  function automatic int unsigned smp_first(input int unsigned prescale);
    return prescale / 2 - 1;
  endfunction

  function automatic int unsigned smp_mid(input int unsigned prescale);
    return prescale / 2;
  endfunction

  function automatic int unsigned smp_last(input int unsigned prescale);
    return prescale / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, 3-sample majority vote and the strobes
// telling the FSM when the vote is ready and when the bit period ends.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rxs,
  output logic bit_maj,
  output logic smp_done,
  output logic last_edge
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] S_FIRST = CW'(smp_first(PRESCALE));
  localparam logic [CW-1:0] S_MID   = CW'(smp_mid(PRESCALE));
  localparam logic [CW-1:0] S_LAST  = CW'(smp_last(PRESCALE));
  localparam logic [CW-1:0] E_LAST  = CW'(PRESCALE - 1);

  logic [CW-1:0] edge_cnt;
  logic          s0, s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      if (!en || edge_cnt == E_LAST) edge_cnt <= '0;
      else                           edge_cnt <= edge_cnt + 1'b1;
      if (en && edge_cnt == S_FIRST) s0 <= rxs;
      if (en && edge_cnt == S_MID)   s1 <= rxs;
    end
  end

  // Third sample is the live synchronized bit; the FSM registers the vote this edge.
  assign bit_maj   = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign smp_done  = en && (edge_cnt == S_LAST);
  assign last_edge = en && (edge_cnt == E_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, walks START/DATA/PARITY/STOP on the
// oversampled majority bit and emits a word strobe or error pulses per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  RX_CLK,
  input  logic                  RX_RST_SYN,
  input  logic                  RX_IN,
  input  logic                  RX_ParEn,
  input  logic                  RX_ParTyp,
  output logic [DATA_WIDTH-1:0] RX_P_DATA,
  output logic                  RX_DataValid,
  output logic                  RX_ParErr,
  output logic                  RX_StpErr
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  uart_state_e           state;
  logic                  sync1, rxs;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q, par_typ_q;
  logic                  par_fail, stp_fail;
  logic                  bit_maj, smp_done, last_edge;
  logic                  stp_now, par_exp;

  always_ff @(posedge RX_CLK) begin
    if (RX_RST_SYN) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rxs   <= sync1;
    end
  end

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk      (RX_CLK),
    .rst      (RX_RST_SYN),
    .en       (state != IDLE),
    .rxs      (rxs),
    .bit_maj  (bit_maj),
    .smp_done (smp_done),
    .last_edge(last_edge)
  );

  // With small prescales the stop vote lands on the exit edge, so fold it in here.
  assign stp_now = stp_fail | (smp_done & ~bit_maj);
  assign par_exp = (^shreg) ^ (par_typ_q == PAR_ODD);

  always_ff @(posedge RX_CLK) begin
    if (RX_RST_SYN) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      par_fail     <= 1'b0;
      stp_fail     <= 1'b0;
      RX_P_DATA    <= '0;
      RX_DataValid <= 1'b0;
      RX_ParErr    <= 1'b0;
      RX_StpErr    <= 1'b0;
    end else begin
      RX_DataValid <= 1'b0;
      RX_ParErr    <= 1'b0;
      RX_StpErr    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state     <= START;
            par_en_q  <= RX_ParEn;
            par_typ_q <= RX_ParTyp;
            par_fail  <= 1'b0;
            stp_fail  <= 1'b0;
          end
        end
        START: begin
          if (smp_done && bit_maj) begin
            state <= IDLE;
          end else if (last_edge) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (smp_done) shreg <= {bit_maj, shreg[DATA_WIDTH-1:1]};
          if (last_edge) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= par_en_q ? PARITY : STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (smp_done && (bit_maj != par_exp)) par_fail <= 1'b1;
          if (last_edge) state <= STOP;
        end
        STOP: begin
          if (smp_done && !bit_maj) stp_fail <= 1'b1;
          if (last_edge) begin
            if (!par_fail && !stp_now) begin
              RX_DataValid <= 1'b1;
              RX_P_DATA    <= shreg;
            end else begin
              RX_ParErr <= par_fail;
              RX_StpErr <= stp_now;
            end
            // rxs here already reflects the bit after the stop bit, so a start bit
            // that follows with no gap is picked up on this edge and frames stay aligned.
            if (!rxs) begin
              state     <= START;
              par_en_q  <= RX_ParEn;
              par_typ_q <= RX_ParTyp;
              par_fail  <= 1'b0;
              stp_fail  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-built corner cases,
// with expected strobes queued at drive time and matched by a negedge monitor.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, rx_in, par_en, par_typ;
  logic [DW-1:0] p_data;
  logic          dv, perr, serr;

  always #5 clk = ~clk;

  uart_rx #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .RX_CLK      (clk),
    .RX_RST_SYN  (rst),
    .RX_IN       (rx_in),
    .RX_ParEn    (par_en),
    .RX_ParTyp   (par_typ),
    .RX_P_DATA   (p_data),
    .RX_DataValid(dv),
    .RX_ParErr   (perr),
    .RX_StpErr   (serr)
  );

  typedef struct {
    logic [7:0] data;
    bit         pen, ptyp, pbit, stop, flip;
    bit         ev, ep, es;
    logic [7:0] ed;
    int         lat;
  } vec_t;

  typedef struct {
    bit         ev, ep, es;
    logic [7:0] ed;
    int         t0, lat;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  int         strobe_cyc[$];
  vec_t       tbl[8];
  int         checks = 0, errors = 0;
  int         cyc = 0;
  int         nstr = 0;
  logic [7:0] model_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dv | perr | serr) begin
        nstr++;
        strobe_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {29'd0, dv, perr, serr}, 32'd0);
        end else begin
          me = sb.pop_front();
          chk({me.name, "_valid"},   dv,          me.ev);
          chk({me.name, "_parerr"},  perr,        me.ep);
          chk({me.name, "_stperr"},  serr,        me.es);
          chk({me.name, "_data"},    p_data,      me.ed);
          chk({me.name, "_latency"}, cyc - me.t0, me.lat);
          if (me.ev) model_data = me.ed;
        end
      end else begin
        chk("data_stable", p_data, model_data);
      end
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (P) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v, input string name, input bit push);
    exp_t e;
    par_en  = v.pen;
    par_typ = v.ptyp;
    if (push) begin
      e.ev = v.ev; e.ep = v.ep; e.es = v.es; e.ed = v.ed;
      e.t0 = cyc;  e.lat = v.lat; e.name = name;
      sb.push_back(e);
    end
    send_bit(1'b0);
    if (v.flip) begin
      par_en  = ~par_en;
      par_typ = ~par_typ;
    end
    for (int i = 0; i < DW; i++) send_bit(v.data[i]);
    if (v.pen) send_bit(v.pbit);
    send_bit(v.stop);
  endtask

  function automatic vec_t good(input logic [7:0] d);
    vec_t v;
    v = '{d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, d, 83};
    return v;
  endfunction

  initial begin
    int n0;
    //           data   pen ptyp pbit stop flip  ev ep es  ed     lat
    tbl[0] = '{8'hA5, 0, 0, 0, 1, 0, 1, 0, 0, 8'hA5, 83};
    tbl[1] = '{8'h3C, 1, 0, 0, 1, 0, 1, 0, 0, 8'h3C, 91};
    tbl[2] = '{8'h3C, 1, 0, 1, 1, 0, 0, 1, 0, 8'h3C, 91};
    tbl[3] = '{8'h01, 1, 1, 0, 0, 0, 0, 0, 1, 8'h3C, 91};
    tbl[4] = '{8'h00, 1, 1, 0, 0, 0, 0, 1, 1, 8'h3C, 91};
    tbl[5] = '{8'h80, 1, 1, 0, 1, 0, 1, 0, 0, 8'h80, 91};
    tbl[6] = '{8'hFF, 0, 0, 0, 1, 1, 1, 0, 0, 8'hFF, 83};
    tbl[7] = '{8'h96, 1, 1, 1, 1, 1, 1, 0, 0, 8'h96, 91};

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  p_data, 0);
    chk("rst_valid", dv,     0);
    chk("rst_parerr", perr,  0);
    chk("rst_stperr", serr,  0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i], $sformatf("vec%0d", i), 1'b1);
      idle(12);
    end

    // short low glitch must not produce anything, then a real frame
    n0 = nstr;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(40);
    chk("glitch_no_strobe", nstr, n0);
    send_frame(good(8'h5A), "glitch_follow", 1'b1);
    idle(12);

    // back-to-back frames with no idle gap
    n0 = strobe_cyc.size();
    send_frame(good(8'h11), "b2b_first", 1'b1);
    send_frame(good(8'hEE), "b2b_second", 1'b1);
    idle(12);
    if (strobe_cyc.size() >= n0 + 2)
      chk("b2b_spacing", strobe_cyc[n0+1] - strobe_cyc[n0], 80);
    else
      chk("b2b_strobe_count", strobe_cyc.size() - n0, 2);

    // reset in the middle of DATA abandons the frame
    n0 = nstr;
    par_en = 1'b0; par_typ = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    model_data = '0;
    @(posedge clk);
    #1;
    chk("midrst_data",   p_data, 0);
    chk("midrst_valid",  dv,     0);
    chk("midrst_parerr", perr,   0);
    chk("midrst_stperr", serr,   0);
    rst = 1'b0;
    idle(100);
    chk("midrst_no_strobe", nstr, n0);
    send_frame(good(8'h77), "after_rst", 1'b1);
    idle(20);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
